// File: rtl/dma_burst_scheduler.sv
// dma_burst_scheduler
//   Sequencing core between the DMA register slave and the AXI read/write
//   masters. A rising edge on i_dma_start (taken only while idle) latches
//   source, destination and byte length, then the transfer is cut into
//   bursts of at most C_MAX_BURST_BEATS beats that never cross a 4 KB page
//   on either side. Every burst is a read command, wait for read done, then
//   a write command, wait for write done; nothing overlaps.
//
// Ports
//   S_AXI_ACLK / S_AXI_ARESETN    clock, async active-low reset
//   i_dma_start                   level start bit (edge detected here)
//   i_src_addr/i_dst_addr/i_trf_len  transfer programming, sampled on start
//   o_rd_cmd_* / i_rd_cmd_ready   read burst command handshake
//   i_rd_done / i_rd_err          read burst completion (err qualified by done)
//   o_wr_cmd_* / i_wr_cmd_ready   write burst command handshake
//   i_wr_done / i_wr_err          write burst completion (err qualified by done)
//   o_busy                        any state but idle
//   o_dma_done                    one-cycle end-of-transfer pulse (also on error)
//   o_error                       sticky error, cleared by the next accepted start
module dma_burst_scheduler #(
  parameter int C_MAX_BURST_BEATS = 16,
  parameter int C_DATA_BYTES      = 4
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic        i_dma_start,
  input  logic [31:0] i_src_addr,
  input  logic [31:0] i_dst_addr,
  input  logic [31:0] i_trf_len,
  output logic        o_rd_cmd_valid,
  input  logic        i_rd_cmd_ready,
  output logic [31:0] o_rd_cmd_addr,
  output logic [7:0]  o_rd_cmd_len,
  input  logic        i_rd_done,
  input  logic        i_rd_err,
  output logic        o_wr_cmd_valid,
  input  logic        i_wr_cmd_ready,
  output logic [31:0] o_wr_cmd_addr,
  output logic [7:0]  o_wr_cmd_len,
  input  logic        i_wr_done,
  input  logic        i_wr_err,
  output logic        o_busy,
  output logic        o_dma_done,
  output logic        o_error
);

  localparam int BEAT_SH = $clog2(C_DATA_BYTES);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_CALC, S_RD_CMD, S_RD_WAIT, S_WR_CMD, S_WR_WAIT, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        start_q;
  logic [31:0] src_q, src_d;
  logic [31:0] dst_q, dst_d;
  logic [31:0] rem_q, rem_d;
  logic [7:0]  len_q, len_d;   // AXI LEN of the current burst (beats-1)
  logic        err_q, err_d;

  logic        start_edge;
  logic [31:0] lim_rem, lim_src, lim_dst, beats, beats_m1, burst_bytes;

  assign start_edge = i_dma_start & ~start_q;

  // Beats left before each limit. The page terms are 1..1024 beats since the
  // pointers are word aligned, so the 4 KB split falls out of a plain min().
  assign lim_rem = rem_q >> BEAT_SH;
  assign lim_src = (32'd4096 - {20'd0, src_q[11:0]}) >> BEAT_SH;
  assign lim_dst = (32'd4096 - {20'd0, dst_q[11:0]}) >> BEAT_SH;

  always_comb begin
    beats = 32'(C_MAX_BURST_BEATS);
    if (lim_rem < beats) beats = lim_rem;
    if (lim_src < beats) beats = lim_src;
    if (lim_dst < beats) beats = lim_dst;
  end

  assign beats_m1    = beats - 32'd1;
  assign burst_bytes = ({24'd0, len_q} + 32'd1) << BEAT_SH;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q <= S_IDLE;
      start_q <= 1'b0;
      src_q   <= '0;
      dst_q   <= '0;
      rem_q   <= '0;
      len_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= i_dma_start;
      src_q   <= src_d;
      dst_q   <= dst_d;
      rem_q   <= rem_d;
      len_q   <= len_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    rem_d   = rem_q;
    len_d   = len_q;
    err_d   = err_q;
    unique case (state_q)
      S_IDLE: begin
        if (start_edge) begin
          src_d   = i_src_addr;
          dst_d   = i_dst_addr;
          rem_d   = i_trf_len;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        // Latched copies hold exactly what the inputs held at the start edge.
        if ((rem_q[1:0] != 2'b00) || (src_q[1:0] != 2'b00) || (dst_q[1:0] != 2'b00)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (rem_q == 32'd0) begin
          state_d = S_DONE;
        end else begin
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        len_d   = beats_m1[7:0];
        state_d = S_RD_CMD;
      end
      S_RD_CMD:  if (i_rd_cmd_ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (i_rd_done) begin
          if (i_rd_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_WR_CMD;
          end
        end
      end
      S_WR_CMD:  if (i_wr_cmd_ready) state_d = S_WR_WAIT;
      S_WR_WAIT: begin
        if (i_wr_done) begin
          if (i_wr_err) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            src_d   = src_q + burst_bytes;
            dst_d   = dst_q + burst_bytes;
            rem_d   = rem_q - burst_bytes;
            state_d = (rem_q == burst_bytes) ? S_DONE : S_CALC;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Command fields come straight from registers, so they cannot move while
  // a command waits for ready.
  assign o_rd_cmd_valid = (state_q == S_RD_CMD);
  assign o_rd_cmd_addr  = src_q;
  assign o_rd_cmd_len   = len_q;
  assign o_wr_cmd_valid = (state_q == S_WR_CMD);
  assign o_wr_cmd_addr  = dst_q;
  assign o_wr_cmd_len   = len_q;
  assign o_busy         = (state_q != S_IDLE);
  assign o_dma_done     = (state_q == S_DONE);
  assign o_error        = err_q;

endmodule

// File: tb/tb_dma_burst_scheduler.sv
module tb_dma_burst_scheduler;

  localparam int DLY   = 5;
  localparam int STALL = 7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] src = '0, dst = '0, len = '0;
  logic        rd_ready = 1'b0, rd_done = 1'b0, rd_err = 1'b0;
  logic        wr_ready = 1'b0, wr_done = 1'b0, wr_err = 1'b0;
  logic        rd_valid, wr_valid, busy, dma_done, error;
  logic [31:0] rd_addr, wr_addr;
  logic [7:0]  rd_len, wr_len;

  always #5 clk = ~clk;

  dma_burst_scheduler #(.C_MAX_BURST_BEATS(16), .C_DATA_BYTES(4)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(rst_n), .i_dma_start(start),
    .i_src_addr(src), .i_dst_addr(dst), .i_trf_len(len),
    .o_rd_cmd_valid(rd_valid), .i_rd_cmd_ready(rd_ready),
    .o_rd_cmd_addr(rd_addr), .o_rd_cmd_len(rd_len),
    .i_rd_done(rd_done), .i_rd_err(rd_err),
    .o_wr_cmd_valid(wr_valid), .i_wr_cmd_ready(wr_ready),
    .o_wr_cmd_addr(wr_addr), .o_wr_cmd_len(wr_len),
    .i_wr_done(wr_done), .i_wr_err(wr_err),
    .o_busy(busy), .o_dma_done(dma_done), .o_error(error)
  );

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  len;
  } cmd_t;

  cmd_t exp_q[$];     // expected commands, pushed when a transfer is kicked
  cmd_t obs[$];       // commands as the DUT handed them over
  int   obs_rd = 0;
  int   n_chk = 0, n_fail = 0;

  // Responder state (written only by the responder process)
  int   done_cnt = 0, rd_hs_cnt = 0, wr_hs_cnt = 0, stable_cnt = 0;
  int   stall_cnt = 0, rd_dly = 0, wr_dly = 0;
  logic [31:0] cap_addr = '0;
  logic [7:0]  cap_len = '0;
  // Responder configuration (written only by the test sequence)
  int   stall_at = -1, wr_err_at = -1;

  // Read/write master model: accepts commands, pulses done DLY cycles later,
  // optionally stalls one read command and flags an error on one write.
  initial begin
    forever begin
      @(negedge clk);
      rd_done = 1'b0; rd_err = 1'b0; wr_done = 1'b0; wr_err = 1'b0;
      rd_ready = 1'b0; wr_ready = 1'b0;
      if (!rst_n) begin
        rd_dly = 0; wr_dly = 0; stall_cnt = 0;
      end else begin
        if (dma_done) done_cnt++;
        if (rd_dly != 0) begin rd_dly--; if (rd_dly == 0) rd_done = 1'b1; end
        if (wr_dly != 0) begin
          wr_dly--;
          if (wr_dly == 0) begin wr_done = 1'b1; wr_err = (wr_hs_cnt == wr_err_at); end
        end
        if (rd_valid) begin
          if (rd_hs_cnt == stall_at && stall_cnt < STALL) begin
            if (stall_cnt == 0) begin cap_addr = rd_addr; cap_len = rd_len; end
            if (rd_addr == cap_addr && rd_len == cap_len) stable_cnt++;
            stall_cnt++;
          end else begin
            rd_ready = 1'b1; rd_hs_cnt++; stall_cnt = 0; rd_dly = DLY;
            obs.push_back('{1'b0, rd_addr, rd_len});
          end
        end
        if (wr_valid) begin
          wr_ready = 1'b1; wr_hs_cnt++; wr_dly = DLY;
          obs.push_back('{1'b1, wr_addr, wr_len});
        end
      end
    end
  end

  task automatic kick(input logic [31:0] s, input logic [31:0] d, input logic [31:0] l);
    @(negedge clk);
    src = s; dst = d; len = l; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_pair(input logic [31:0] s, input logic [31:0] d, input logic [7:0] l);
    exp_q.push_back('{1'b0, s, l});
    exp_q.push_back('{1'b1, d, l});
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_chk++; if ({rd_valid, wr_valid, busy, dma_done, error} !== 5'b0) begin
      n_fail++; $display("FAIL reset_ctl: got %b expected 00000", {rd_valid, wr_valid, busy, dma_done, error});
    end
    n_chk++; if ({rd_addr, wr_addr, rd_len, wr_len} !== 80'd0) begin
      n_fail++; $display("FAIL reset_cmd: got %h expected 0", {rd_addr, wr_addr, rd_len, wr_len});
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_burst;
    int base;
    base = done_cnt;
    push_pair(32'h1000, 32'h2000, 8'd15);
    @(negedge clk); src = 32'h1000; dst = 32'h2000; len = 32'd64; start = 1'b1;
    @(negedge clk); start = 1'b0;       // CHECK
    @(negedge clk);                     // CALC
    n_chk++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b expected 0", rd_valid); end
    @(negedge clk);                     // RD_CMD
    n_chk++; if ({rd_valid, rd_addr, rd_len} !== {1'b1, 32'h1000, 8'd15}) begin
      n_fail++; $display("FAIL single_latency: got v=%b a=%h l=%0d expected v=1 a=00001000 l=15", rd_valid, rd_addr, rd_len);
    end
    for (int c = 0; c < 500 && done_cnt == base; c++) @(posedge clk);
    repeat (5) @(posedge clk);
    n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL single_done_count: got %0d expected %0d", done_cnt - base, 1); end
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL single_error: got %b expected 0", error); end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL single_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL single_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
    n_chk++; if (obs.size() != obs_rd) begin n_fail++; $display("FAIL single_extra_cmds: got %0d expected 0", obs.size() - obs_rd); end
  endtask

  task automatic test_multi_burst;
    int base;
    base = done_cnt;
    for (int i = 0; i < 8; i++) push_pair(32'h40 * i, 32'h8000 + 32'h40 * i, 8'd15);
    kick(32'h0, 32'h8000, 32'h200);
    for (int c = 0; c < 2000 && done_cnt == base; c++) @(posedge clk);
    n_chk++; if (wr_hs_cnt - (obs.size() - obs_rd) / 2 < 0 || obs.size() - obs_rd != 16) begin
      n_fail++; $display("FAIL multi_cmd_count: got %0d expected 16", obs.size() - obs_rd);
    end
    repeat (5) @(posedge clk);
    n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL multi_done_count: got %0d expected 1", done_cnt - base); end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL multi_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL multi_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_4k_split;
    int base;
    // source-side page limit, then destination-side page limit
    push_pair(32'h0FF0, 32'h3000, 8'd3);
    push_pair(32'h1000, 32'h3010, 8'd11);
    push_pair(32'h0000, 32'h1FF8, 8'd1);
    push_pair(32'h0008, 32'h2000, 8'd13);
    base = done_cnt;
    kick(32'h0FF0, 32'h3000, 32'd64);
    for (int c = 0; c < 1000 && done_cnt == base; c++) @(posedge clk);
    kick(32'h0000, 32'h1FF8, 32'd64);
    for (int c = 0; c < 1000 && done_cnt == base + 1; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_chk++; if (done_cnt !== base + 2) begin n_fail++; $display("FAIL split_done_count: got %0d expected 2", done_cnt - base); end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL split_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL split_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
    n_chk++; if (obs.size() != obs_rd) begin n_fail++; $display("FAIL split_extra_cmds: got %0d expected 0", obs.size() - obs_rd); end
  endtask

  task automatic test_boundary_starts;
    int base, busy_seen;
    // zero length: done two cycles after the edge, nothing issued
    @(negedge clk); src = 32'h0; dst = 32'h0; len = 32'h0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    n_chk++; if ({busy, dma_done} !== 2'b10) begin n_fail++; $display("FAIL zero_check_cycle: got busy,done=%b expected 10", {busy, dma_done}); end
    @(negedge clk);
    n_chk++; if (dma_done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got %b expected 1", dma_done); end
    @(negedge clk);
    n_chk++; if ({busy, dma_done} !== 2'b00) begin n_fail++; $display("FAIL zero_idle: got %b expected 00", {busy, dma_done}); end
    // misaligned length: error and done, no commands
    base = done_cnt;
    kick(32'h1000, 32'h2000, 32'h41);
    for (int c = 0; c < 50 && done_cnt == base; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL misaligned_error: got %b expected 1", error); end
    n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL misaligned_done: got %0d expected 1", done_cnt - base); end
    // start held high after completion must not retrigger
    base = done_cnt;
    @(negedge clk); len = 32'h40; src = 32'h0; dst = 32'h4000; start = 1'b1;
    push_pair(32'h0, 32'h4000, 8'd15);
    for (int c = 0; c < 500 && done_cnt == base; c++) @(posedge clk);
    busy_seen = 0;
    repeat (2) @(negedge clk);
    repeat (100) begin @(negedge clk); if (busy) busy_seen++; end
    start = 1'b0;
    n_chk++; if (busy_seen !== 0) begin n_fail++; $display("FAIL held_start_busy: got %0d expected 0", busy_seen); end
    n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL held_start_done: got %0d expected 1", done_cnt - base); end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL held_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL held_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
    n_chk++; if (obs.size() != obs_rd) begin n_fail++; $display("FAIL boundary_extra_cmds: got %0d expected 0", obs.size() - obs_rd); end
  endtask

  task automatic test_backpressure_error;
    int base, stab0;
    // read ready held low for 7 cycles on the first command
    stab0 = stable_cnt;
    stall_at = rd_hs_cnt;
    base = done_cnt;
    push_pair(32'h5000, 32'h6000, 8'd15);
    kick(32'h5000, 32'h6000, 32'd64);
    for (int c = 0; c < 500 && done_cnt == base; c++) @(posedge clk);
    n_chk++; if (stable_cnt - stab0 !== STALL) begin n_fail++; $display("FAIL stall_stable: got %0d expected %0d", stable_cnt - stab0, STALL); end
    // write error on burst 2 of 4: no burst 3
    stall_at = -1;
    wr_err_at = wr_hs_cnt + 2;
    base = done_cnt;
    push_pair(32'h0, 32'h4000, 8'd15);
    push_pair(32'h40, 32'h4040, 8'd15);
    kick(32'h0, 32'h4000, 32'h100);
    for (int c = 0; c < 1000 && done_cnt == base; c++) @(posedge clk);
    repeat (20) @(posedge clk);
    wr_err_at = -1;
    n_chk++; if (error !== 1'b1) begin n_fail++; $display("FAIL wr_err_flag: got %b expected 1", error); end
    n_chk++; if (done_cnt !== base + 1) begin n_fail++; $display("FAIL wr_err_done: got %0d expected 1", done_cnt - base); end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL bp_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL bp_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
    n_chk++; if (obs.size() != obs_rd) begin n_fail++; $display("FAIL wr_err_extra_cmds: got %0d expected 0", obs.size() - obs_rd); end
    // next accepted start clears the sticky error
    base = done_cnt;
    push_pair(32'h7000, 32'h9000, 8'd15);
    kick(32'h7000, 32'h9000, 32'd64);
    n_chk++; if (error !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", error); end
    for (int c = 0; c < 500 && done_cnt == base; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL clear_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL clear_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  task automatic test_reset_mid;
    int base, rd0;
    base = done_cnt;
    rd0 = rd_hs_cnt;
    kick(32'h0, 32'h4000, 32'h100);
    for (int c = 0; c < 1000 && rd_hs_cnt < rd0 + 3; c++) @(posedge clk);
    n_chk++; if (rd_hs_cnt !== rd0 + 3) begin n_fail++; $display("FAIL rstmid_reach_burst3: got %0d expected 3", rd_hs_cnt - rd0); end
    repeat (2) @(negedge clk);          // burst 3 read is in flight
    #2 rst_n = 1'b0;
    #1;
    n_chk++; if ({rd_valid, wr_valid, busy, dma_done} !== 4'b0) begin
      n_fail++; $display("FAIL rstmid_outputs: got %b expected 0000", {rd_valid, wr_valid, busy, dma_done});
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    n_chk++; if (done_cnt !== base) begin n_fail++; $display("FAIL rstmid_no_done: got %0d expected 0", done_cnt - base); end
    n_chk++; if (obs.size() - obs_rd !== 5) begin n_fail++; $display("FAIL rstmid_partial_cmds: got %0d expected 5", obs.size() - obs_rd); end
    obs_rd = obs.size();
    push_pair(32'h1000, 32'h2000, 8'd15);
    kick(32'h1000, 32'h2000, 32'd64);
    for (int c = 0; c < 500 && done_cnt == base; c++) @(posedge clk);
    repeat (3) @(posedge clk);
    n_chk++; if ({done_cnt - base, 31'(error)} !== {32'd1, 31'd0}) begin
      n_fail++; $display("FAIL rstmid_clean_run: got done=%0d err=%b expected done=1 err=0", done_cnt - base, error);
    end
    while (exp_q.size() > 0) begin
      cmd_t e;
      e = exp_q.pop_front();
      n_chk++;
      if (obs_rd >= obs.size()) begin n_fail++; $display("FAIL rstmid_cmd: got none expected %h", e); end
      else begin
        if (obs[obs_rd] !== e) begin n_fail++; $display("FAIL rstmid_cmd: got %h expected %h", obs[obs_rd], e); end
        obs_rd++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_multi_burst();
    test_4k_split();
    test_boundary_starts();
    test_backpressure_error();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
